// File: rtl/laser_scan.sv
// laser_scan: loads NPTS points, then alternately places two laser circles
// to maximise covered points. Ports: CLK, RST_N, VALID, X, Y in; C1X..C2Y, COUNT, DONE out.
module laser_scan #(
  parameter int NPTS     = 40,
  parameter int CW       = 4,
  parameter int R2       = 16,
  parameter int MAX_ITER = 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          VALID,
  input  logic [CW-1:0] X,
  input  logic [CW-1:0] Y,
  output logic [CW-1:0] C1X,
  output logic [CW-1:0] C1Y,
  output logic [CW-1:0] C2X,
  output logic [CW-1:0] C2Y,
  output logic [7:0]    COUNT,
  output logic          DONE
);

  localparam int IW = $clog2(NPTS);
  localparam int SW = 2*CW+1;

  typedef enum logic [2:0] {
    LOAD, SCAN1, SCAN2, CHECK, OUT
  } state_t;

  state_t        r_state, w_next;

  logic [CW-1:0] r_px [NPTS];
  logic [CW-1:0] r_py [NPTS];

  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cx, r_cy;
  logic [CW-1:0] r_bx, r_by;
  logic [CW-1:0] r_c1x, r_c1y;
  logic [CW-1:0] r_c2x, r_c2y;
  logic          r_c2_en;
  logic [7:0]    r_acc, r_best;
  logic [7:0]    r_prev, r_pass;

  logic [CW-1:0] r_o_c1x, r_o_c1y;
  logic [CW-1:0] r_o_c2x, r_o_c2y;
  logic [7:0]    r_o_cnt;
  logic          r_done;

  function automatic logic f_hit(
    input logic [CW-1:0] px,
    input logic [CW-1:0] py,
    input logic [CW-1:0] cx,
    input logic [CW-1:0] cy
  );
    logic [CW-1:0]   dx, dy;
    logic [2*CW-1:0] sx, sy;
    logic [SW-1:0]   sum;
    dx  = (px >= cx) ? px - cx : cx - px;
    dy  = (py >= cy) ? py - cy : cy - py;
    sx  = {{CW{1'b0}}, dx} * {{CW{1'b0}}, dx};
    sy  = {{CW{1'b0}}, dy} * {{CW{1'b0}}, dy};
    sum = {1'b0, sx} + {1'b0, sy};
    return 32'(sum) <= R2;
  endfunction

  logic [CW-1:0] w_px, w_py;
  logic          w_lastp, w_lastc;
  logic          w_cand, w_fix, w_cov;
  logic [7:0]    w_score, w_nb;
  logic          w_better;
  logic [CW-1:0] w_nbx, w_nby;
  logic [7:0]    w_pass_n;
  logic          w_stop;

  assign w_px    = r_px[r_idx];
  assign w_py    = r_py[r_idx];
  assign w_lastp = (r_idx == IW'(NPTS-1));
  assign w_lastc = (&r_cx) & (&r_cy);

  // SCAN1: candidate is C1, C2 fixed (off in first pass).
  // SCAN2: candidate is C2, C1 fixed.
  assign w_cand  = f_hit(w_px, w_py, r_cx, r_cy);
  assign w_fix   = (r_state == SCAN1)
                 ? (r_c2_en & f_hit(w_px, w_py, r_c2x, r_c2y))
                 : f_hit(w_px, w_py, r_c1x, r_c1y);
  assign w_cov   = w_cand | w_fix;
  assign w_score = r_acc + {7'd0, w_cov};

  assign w_better = w_score > r_best;
  assign w_nb     = w_better ? w_score : r_best;
  assign w_nbx    = w_better ? r_cx : r_bx;
  assign w_nby    = w_better ? r_cy : r_by;

  assign w_pass_n = r_pass + 8'd1;
  assign w_stop   = (r_best <= r_prev)
                  | (w_pass_n == 8'(MAX_ITER));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= LOAD;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      LOAD:  if (VALID && w_lastp)   w_next = SCAN1;
      SCAN1: if (w_lastp && w_lastc) w_next = SCAN2;
      SCAN2: if (w_lastp && w_lastc) w_next = CHECK;
      CHECK: w_next = w_stop ? OUT : SCAN1;
      OUT:   w_next = LOAD;
      default: w_next = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (r_state == LOAD && VALID) begin
      r_px[r_idx] <= X;
      r_py[r_idx] <= Y;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_idx   <= '0;
      r_cx    <= '0;
      r_cy    <= '0;
      r_bx    <= '0;
      r_by    <= '0;
      r_c1x   <= '0;
      r_c1y   <= '0;
      r_c2x   <= '0;
      r_c2y   <= '0;
      r_c2_en <= 1'b0;
      r_acc   <= '0;
      r_best  <= '0;
      r_prev  <= '0;
      r_pass  <= '0;
      r_o_c1x <= '0;
      r_o_c1y <= '0;
      r_o_c2x <= '0;
      r_o_c2y <= '0;
      r_o_cnt <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        LOAD: begin
          r_cx    <= '0;
          r_cy    <= '0;
          r_acc   <= '0;
          r_best  <= '0;
          r_c2_en <= 1'b0;
          if (VALID) r_idx <= w_lastp ? '0 : r_idx + 1'b1;
        end
        SCAN1, SCAN2: begin
          if (!w_lastp) begin
            r_idx <= r_idx + 1'b1;
            r_acc <= w_score;
          end else begin
            r_idx  <= '0;
            r_acc  <= '0;
            r_best <= w_nb;
            r_bx   <= w_nbx;
            r_by   <= w_nby;
            r_cx   <= r_cx + 1'b1;
            if (&r_cx) r_cy <= r_cy + 1'b1;
            if (w_lastc) begin
              if (r_state == SCAN1) begin
                r_c1x  <= w_nbx;
                r_c1y  <= w_nby;
                r_best <= '0;
              end else begin
                r_c2x   <= w_nbx;
                r_c2y   <= w_nby;
                r_c2_en <= 1'b1;
              end
            end
          end
        end
        CHECK: begin
          r_pass <= w_pass_n;
          if (!w_stop) begin
            r_prev <= r_best;
            r_best <= '0;
          end
        end
        OUT: begin
          r_o_c1x <= r_c1x;
          r_o_c1y <= r_c1y;
          r_o_c2x <= r_c2x;
          r_o_c2y <= r_c2y;
          r_o_cnt <= r_best;
          r_done  <= 1'b1;
          r_idx   <= '0;
          r_pass  <= '0;
          r_prev  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign C1X   = r_o_c1x;
  assign C1Y   = r_o_c1y;
  assign C2X   = r_o_c2x;
  assign C2Y   = r_o_c2y;
  assign COUNT = r_o_cnt;
  assign DONE  = r_done;

endmodule
